// File: rtl/breakout_game_ctrl_if.sv
// Signal bundle between the Breakout sequencer and its surroundings (vga row, game events,
// object strobes and score/status outputs read by the colour logic).
interface breakout_game_ctrl_if #(
  parameter int unsigned NUM_BRICKS = 12
) ();
  logic [8:0]            row;
  logic                  start_press;
  logic                  ball_miss;
  logic                  hit_valid;
  logic [4:0]            hit_id;
  logic                  paddle_step;
  logic                  ball_step;
  logic                  ball_serve;
  logic [NUM_BRICKS-1:0] brick_alive;
  logic [1:0]            lives;
  logic [7:0]            score;
  logic [2:0]            game_state;

  modport master (
    output row, start_press, ball_miss, hit_valid, hit_id,
    input  paddle_step, ball_step, ball_serve, brick_alive, lives, score, game_state
  );

  modport slave (
    input  row, start_press, ball_miss, hit_valid, hit_id,
    output paddle_step, ball_step, ball_serve, brick_alive, lives, score, game_state
  );
endinterface

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: per-frame tick, ordered paddle/ball strobes, game FSM, bricks/lives/score.
// Optional BREAKOUT_SPEEDUP_EN: a second ball_step per PLAY frame once score reaches 6.
module breakout_game_ctrl #(
  parameter int unsigned FRAME_ROW  = 480,
  parameter int unsigned BALL_GAP   = 4,
  parameter int unsigned LIVES      = 3,
  parameter int unsigned NUM_BRICKS = 12
) (
  input logic                 clock,
  input logic                 reset,
  breakout_game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StMiss  = 3'd3,
    StOver  = 3'd4,
    StWin   = 3'd5
  } state_e;

  localparam int unsigned GapW = $clog2(BALL_GAP + 1);

  state_e                state_q, state_d;
  logic [8:0]            row_q;
  logic                  frame_start;
  logic                  paddle_q, paddle_d;
  logic                  ball_q, ball_d;
  logic                  serve_q, serve_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic [NUM_BRICKS-1:0] mask_q, mask_d, hit_bits;
  logic [1:0]            lives_q, lives_d;
  logic [7:0]            score_q, score_d;
`ifdef BREAKOUT_SPEEDUP_EN
  logic                  second_q, second_d;
`endif

  function automatic logic [NUM_BRICKS-1:0] id_to_bit(input logic [4:0] id);
    logic [NUM_BRICKS-1:0] b;
    b = '0;
    if (id >= 5'd1 && id <= 5'd6) begin
      b = NUM_BRICKS'(1) << (id - 5'd1);
    end else if (id >= 5'd8 && id <= 5'd13) begin
      b = NUM_BRICKS'(1) << (id - 5'd2);
    end
    return b;
  endfunction

  assign frame_start = (bus.row == 9'(FRAME_ROW)) && (row_q != 9'(FRAME_ROW));
  assign hit_bits    = id_to_bit(bus.hit_id) & mask_q;

  always_comb begin
    paddle_d = frame_start && (state_q inside {StServe, StPlay, StMiss});
    ball_d   = (gap_q == GapW'(1)) && (state_q == StPlay);
    gap_d    = gap_q;
`ifdef BREAKOUT_SPEEDUP_EN
    second_d = second_q;
`endif
    if (paddle_d) begin
      gap_d = GapW'(BALL_GAP);
`ifdef BREAKOUT_SPEEDUP_EN
      second_d = 1'b0;
`endif
    end else if (gap_q != '0) begin
      gap_d = gap_q - GapW'(1);
    end
`ifdef BREAKOUT_SPEEDUP_EN
    // Re-arm the gap counter once for the second ball step of a fast frame.
    if (ball_d && !second_q && (score_q >= 8'd6)) begin
      gap_d    = GapW'(BALL_GAP);
      second_d = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    lives_d = lives_q;
    score_d = score_q;
    serve_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start_press) begin
          state_d = StServe;
          serve_d = 1'b1;
        end
      end
      StServe: begin
        if (frame_start) state_d = StPlay;
      end
      StPlay: begin
        if (bus.hit_valid && (hit_bits != '0)) begin
          mask_d = mask_q & ~hit_bits;
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
        end
        // Clearing the last brick wins even if the ball was missed in the same cycle.
        if (mask_d == '0) begin
          state_d = StWin;
        end else if (bus.ball_miss) begin
          state_d = StMiss;
          if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
        end
      end
      StMiss: begin
        if (lives_q == 2'd0) begin
          state_d = StOver;
        end else if (bus.start_press) begin
          state_d = StServe;
          serve_d = 1'b1;
        end
      end
      StOver, StWin: begin
        if (bus.start_press) begin
          state_d = StServe;
          serve_d = 1'b1;
          mask_d  = '1;
          lives_d = 2'(LIVES);
          score_d = 8'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    // Row keeps tracking through reset so a reset inside blanking cannot fake a new frame.
    row_q <= bus.row;
    if (reset) begin
      state_q  <= StIdle;
      paddle_q <= 1'b0;
      ball_q   <= 1'b0;
      serve_q  <= 1'b0;
      gap_q    <= '0;
      mask_q   <= '1;
      lives_q  <= 2'(LIVES);
      score_q  <= 8'd0;
`ifdef BREAKOUT_SPEEDUP_EN
      second_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      paddle_q <= paddle_d;
      ball_q   <= ball_d;
      serve_q  <= serve_d;
      gap_q    <= gap_d;
      mask_q   <= mask_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
`ifdef BREAKOUT_SPEEDUP_EN
      second_q <= second_d;
`endif
    end
  end

  assign bus.paddle_step = paddle_q;
  assign bus.ball_step   = ball_q;
  assign bus.ball_serve  = serve_q;
  assign bus.brick_alive = mask_q;
  assign bus.lives       = lives_q;
  assign bus.score       = score_q;
  assign bus.game_state  = state_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Bench for breakout_game_ctrl: strobe scoreboard (expected events queued at stimulus time,
// matched as the DUT emits them) plus a small game-state model compared after each scenario.
module tb_breakout_game_ctrl;

  localparam int BallGap = 4;
  localparam logic [2:0] SIdle = 3'd0, SServe = 3'd1, SPlay = 3'd2;
  localparam logic [2:0] SMiss = 3'd3, SOver = 3'd4, SWin = 3'd5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    int kind;
    int at;
  } ev_t;
  ev_t exp_q[$];

  logic [2:0]  m_state;
  logic [11:0] m_mask;
  logic [1:0]  m_lives;
  logic [7:0]  m_score;

  breakout_game_ctrl_if #(.NUM_BRICKS(12)) bus ();

  breakout_game_ctrl #(
    .FRAME_ROW (480),
    .BALL_GAP  (BallGap),
    .LIVES     (3),
    .NUM_BRICKS(12)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #10 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic string kname(input int k);
    return (k == 0) ? "paddle_step" : (k == 1) ? "ball_step" : "ball_serve";
  endfunction

  // Scoreboard: every strobe seen must be the next expected event at the expected cycle.
  logic mon_s;
  ev_t  mon_e;
  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      mon_s = (k == 0) ? bus.paddle_step : (k == 1) ? bus.ball_step : bus.ball_serve;
      if (mon_s === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL strobe: got unexpected %s at cycle %0d, required none", kname(k), cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.kind != k || mon_e.at != cyc) begin
            failures++;
            $display("FAIL strobe: got %s at cycle %0d, required %s at cycle %0d",
                     kname(k), cyc, kname(mon_e.kind), mon_e.at);
          end
        end
      end
    end
  end

  function automatic void push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    m_state = SIdle;
    m_mask  = 12'hFFF;
    m_lives = 2'd3;
    m_score = 8'd0;
  endfunction

  task automatic do_frame();
    int fs;
    @(posedge clock);
    #1 bus.row = 9'd480;
    fs = cyc;
    if (m_state inside {SServe, SPlay, SMiss}) begin
      if (m_state == SServe) m_state = SPlay;
      push_ev(0, fs + 1);
      if (m_state == SPlay) begin
        push_ev(1, fs + 1 + BallGap);
`ifdef BREAKOUT_SPEEDUP_EN
        if (m_score >= 8'd6) push_ev(1, fs + 1 + 2 * BallGap);
`endif
      end
    end
    repeat (12) @(posedge clock);
    #1 bus.row = 9'd0;
    repeat (4) @(posedge clock);
  endtask

  task automatic press_start();
    @(posedge clock);
    #1 bus.start_press = 1'b1;
    if (m_state inside {SIdle, SMiss, SOver, SWin}) begin
      if (m_state inside {SOver, SWin}) begin
        m_mask  = 12'hFFF;
        m_lives = 2'd3;
        m_score = 8'd0;
      end
      m_state = SServe;
      push_ev(2, cyc + 1);
    end
    @(posedge clock);
    #1 bus.start_press = 1'b0;
    @(posedge clock);
  endtask

  task automatic pulse(input bit hit, input int id, input bit miss);
    int idx;
    @(posedge clock);
    #1;
    bus.hit_valid = hit;
    bus.hit_id    = 5'(id);
    bus.ball_miss = miss;
    if (m_state == SPlay) begin
      idx = (id >= 1 && id <= 6) ? id - 1 : (id >= 8 && id <= 13) ? id - 2 : -1;
      if (hit && idx >= 0 && m_mask[idx]) begin
        m_mask[idx] = 1'b0;
        if (m_score != 8'hFF) m_score = m_score + 8'd1;
      end
      if (m_mask == 12'h000) begin
        m_state = SWin;
      end else if (miss) begin
        m_state = SMiss;
        if (m_lives != 2'd0) m_lives = m_lives - 2'd1;
      end
    end
    @(posedge clock);
    #1;
    bus.hit_valid = 1'b0;
    bus.ball_miss = 1'b0;
    bus.hit_id    = 5'd0;
    @(posedge clock);
    #1;
    if (m_state == SMiss && m_lives == 2'd0) m_state = SOver;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    checks++;
    if (bus.game_state !== SIdle || bus.brick_alive !== 12'hFFF) begin
      failures++;
      $display("FAIL reset_state: got state=%0d mask=%h, required state=0 mask=fff",
               bus.game_state, bus.brick_alive);
    end
    checks++;
    if (bus.lives !== 2'd3 || bus.score !== 8'd0) begin
      failures++;
      $display("FAIL reset_counts: got lives=%0d score=%0d, required lives=3 score=0",
               bus.lives, bus.score);
    end
    checks++;
    if ({bus.paddle_step, bus.ball_step, bus.ball_serve} !== 3'b000) begin
      failures++;
      $display("FAIL reset_strobes: got %b, required 000",
               {bus.paddle_step, bus.ball_step, bus.ball_serve});
    end
    repeat (3) do_frame();
    checks++;
    if (bus.game_state !== m_state || bus.brick_alive !== m_mask || exp_q.size() != 0) begin
      failures++;
      $display("FAIL idle_frames: got state=%0d mask=%h pending=%0d, required state=%0d mask=%h 0",
               bus.game_state, bus.brick_alive, exp_q.size(), m_state, m_mask);
    end
  endtask

  task automatic test_serve();
    press_start();
    checks++;
    if (bus.game_state !== m_state) begin
      failures++;
      $display("FAIL serve_state: got %0d, required %0d", bus.game_state, m_state);
    end
    do_frame();
    checks++;
    if (bus.game_state !== m_state || exp_q.size() != 0) begin
      failures++;
      $display("FAIL serve_to_play: got state=%0d pending=%0d, required state=%0d pending=0",
               bus.game_state, exp_q.size(), m_state);
    end
  endtask

  task automatic test_hits();
    pulse(1'b1, 3, 1'b0);
    pulse(1'b1, 3, 1'b0);
    pulse(1'b1, 7, 1'b0);
    checks++;
    if (bus.brick_alive !== m_mask || bus.score !== m_score) begin
      failures++;
      $display("FAIL hits: got mask=%h score=%0d, required mask=%h score=%0d",
               bus.brick_alive, bus.score, m_mask, m_score);
    end
    press_start();
    checks++;
    if (bus.game_state !== m_state) begin
      failures++;
      $display("FAIL start_in_play: got state=%0d, required %0d", bus.game_state, m_state);
    end
  endtask

  task automatic test_miss_over();
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 0, 1'b1);
      checks++;
      if (bus.lives !== m_lives || bus.game_state !== m_state) begin
        failures++;
        $display("FAIL miss_%0d: got lives=%0d state=%0d, required lives=%0d state=%0d",
                 i, bus.lives, bus.game_state, m_lives, m_state);
      end
      pulse(1'b1, 1, 1'b0);
      checks++;
      if (bus.brick_alive !== m_mask || bus.score !== m_score) begin
        failures++;
        $display("FAIL hit_outside_play_%0d: got mask=%h score=%0d, required mask=%h score=%0d",
                 i, bus.brick_alive, bus.score, m_mask, m_score);
      end
      if (i == 0) do_frame();
      if (i < 2) begin
        press_start();
        do_frame();
      end
    end
    press_start();
    checks++;
    if (bus.game_state !== m_state || bus.lives !== m_lives || bus.score !== m_score ||
        bus.brick_alive !== m_mask) begin
      failures++;
      $display("FAIL new_game: got st=%0d lives=%0d score=%0d mask=%h, need %0d %0d %0d %h",
               bus.game_state, bus.lives, bus.score, bus.brick_alive,
               m_state, m_lives, m_score, m_mask);
    end
  endtask

  task automatic test_win();
    do_frame();
    for (int id = 1; id <= 6; id++) pulse(1'b1, id, 1'b0);
    do_frame();
    checks++;
    if (exp_q.size() != 0 || bus.score !== m_score) begin
      failures++;
      $display("FAIL fast_frame: got pending=%0d score=%0d, required 0 and %0d",
               exp_q.size(), bus.score, m_score);
    end
    for (int id = 8; id <= 12; id++) pulse(1'b1, id, 1'b0);
    pulse(1'b1, 13, 1'b1);
    checks++;
    if (bus.game_state !== m_state || bus.lives !== m_lives || bus.score !== m_score ||
        bus.brick_alive !== m_mask) begin
      failures++;
      $display("FAIL win: got st=%0d lives=%0d score=%0d mask=%h, need %0d %0d %0d %h",
               bus.game_state, bus.lives, bus.score, bus.brick_alive,
               m_state, m_lives, m_score, m_mask);
    end
    do_frame();
    press_start();
    checks++;
    if (bus.game_state !== m_state || bus.brick_alive !== m_mask || bus.score !== m_score) begin
      failures++;
      $display("FAIL win_restart: got st=%0d mask=%h score=%0d, need %0d %h %0d",
               bus.game_state, bus.brick_alive, bus.score, m_state, m_mask, m_score);
    end
  endtask

  task automatic test_reset_mid_gap();
    int fs;
    do_frame();
    @(posedge clock);
    #1 bus.row = 9'd480;
    fs = cyc;
    push_ev(0, fs + 1);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    repeat (10) @(posedge clock);
    #1 bus.row = 9'd0;
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (bus.game_state !== m_state || exp_q.size() != 0 || bus.brick_alive !== m_mask) begin
      failures++;
      $display("FAIL reset_mid_gap: got st=%0d pending=%0d mask=%h, need %0d 0 %h",
               bus.game_state, exp_q.size(), bus.brick_alive, m_state, m_mask);
    end
  endtask

  initial begin
    bus.row         = 9'd0;
    bus.start_press = 1'b0;
    bus.ball_miss   = 1'b0;
    bus.hit_valid   = 1'b0;
    bus.hit_id      = 5'd0;
    model_reset();
    test_reset();
    test_serve();
    test_hits();
    test_miss_over();
    test_win();
    test_reset_mid_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
